// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR random-number generator:
//   - state_e       : draw FSM states (IDLE / DRAW / OUT)
//   - DEFAULT_TAPS  : maximal-length feedback mask for an 8-bit LFSR
//   - DEFAULT_SEED  : 8-bit reset / fallback seed (nonzero)
// ----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'h93;

endpackage

// File: rtl/lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// Fibonacci-style shift register: shifts left, feedback bit is the parity of
// the tapped state bits. A seed load has priority over a step, and a zero
// seed is replaced by SEED so the register can never reach the all-zero
// lock-up state.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (state <- SEED)
//   step_i   in   advance one step
//   load_i   in   load seed_i (overrides step_i)
//   seed_i   in   WIDTH  seed value to load
//   state_o  out  WIDTH  current register state
// ----------------------------------------------------------------------------
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = lfsr_pkg::DEFAULT_SEED,
    parameter logic [WIDTH-1:0] TAPS  = lfsr_pkg::DEFAULT_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? SEED : seed_i;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/lfsr_rng.sv
// ----------------------------------------------------------------------------
// lfsr_rng
// LFSR random-number generator with a bounded-draw engine. In IDLE the LFSR
// free-runs while en is high. A req in IDLE latches range_in and starts a
// draw: every DRAW cycle the low bits of the LFSR (masked to the smallest
// all-ones value covering range-1) are tested and accepted if below the
// range (rejection sampling). The accepted value is presented in OUT until
// the consumer takes it with rnd_ready.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req; LFSR steps when en=1
// DRAW  | testing one masked candidate per cycle; LFSR steps every cycle
// OUT   | rnd_out/rnd_valid held until rnd_ready; LFSR frozen
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   free-run step enable (IDLE only)
//   seed_we    in   load seed_in (zero loads SEED)
//   seed_in    in   WIDTH  seed value
//   lfsr_q     out  WIDTH  current LFSR state
//   req        in   start a bounded draw (sampled in IDLE only)
//   range_in   in   WIDTH  exclusive upper bound, 0 = full range
//   rnd_valid  out  draw result available
//   rnd_ready  in   consumer accepts the result
//   rnd_out    out  WIDTH  draw result
//   busy       out  high in DRAW or OUT
// ----------------------------------------------------------------------------
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr_q,
    input  logic             req,
    input  logic [WIDTH-1:0] range_in,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [WIDTH-1:0] rnd_out,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] range_q, range_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] out_q,   out_d;

    logic             step;
    logic [WIDTH-1:0] cand;
    logic             accept;

    // Smallest all-ones value >= r-1: smear the highest set bit of r-1
    // downwards. A full-range draw (r==0) uses every bit; ranges above
    // 2^(WIDTH-1) fall out naturally because r-1 has its top bit set.
    function automatic logic [WIDTH-1:0] calc_mask(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] m;
        if (r == '0) begin
            m = '1;
        end else begin
            m = r - ONE;
            for (int i = 0; i < WIDTH; i++) begin
                m = m | (m >> 1);
            end
        end
        return m;
    endfunction

    assign step = ((state_q == IDLE) && en) || (state_q == DRAW);

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_i  (step),
        .load_i  (seed_we),
        .seed_i  (seed_in),
        .state_o (lfsr_q)
    );

    assign cand   = lfsr_q & mask_q;
    assign accept = (range_q == '0) || (cand < range_q);

    always_comb begin
        state_d = state_q;
        range_d = range_q;
        mask_d  = mask_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    range_d = range_in;
                    mask_d  = calc_mask(range_in);
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (accept) begin
                    out_d   = cand;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (rnd_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            range_q <= '0;
            mask_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            range_q <= range_d;
            mask_q  <= mask_d;
            out_q   <= out_d;
        end
    end

    assign rnd_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign rnd_out   = out_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng
// Self-checking bench for lfsr_rng (WIDTH=8 defaults). The reference model
// is the full 255-entry LFSR sequence plus a position index; draws are
// predicted by scanning that sequence with a power-of-two mask.
// ----------------------------------------------------------------------------
module tb_lfsr_rng;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       en        = 1'b0;
    logic       seed_we   = 1'b0;
    logic [7:0] seed_in   = 8'h00;
    logic       req       = 1'b0;
    logic [7:0] range_in  = 8'h00;
    logic       rnd_ready = 1'b0;
    logic [7:0] lfsr_q;
    logic       rnd_valid;
    logic [7:0] rnd_out;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    int seq [255];
    int pos;

    lfsr_rng dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seed_we   (seed_we),
        .seed_in   (seed_in),
        .lfsr_q    (lfsr_q),
        .req       (req),
        .range_in  (range_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd_out   (rnd_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int step_ref(input int v);
        int ones;
        ones = 0;
        for (int b = 0; b < 8; b++) begin
            if (((v & 'hB8) >> b) % 2 == 1) ones++;
        end
        return ((v * 2) % 256) + (ones % 2);
    endfunction

    function automatic int idx_of(input int v);
        for (int i = 0; i < 255; i++) begin
            if (seq[i] == v) return i;
        end
        return 0;
    endfunction

    function automatic int mask_ref(input int r);
        int p;
        if (r == 0) return 255;
        p = 1;
        while (p < r) p = p * 2;
        return p - 1;
    endfunction

    function automatic int cur();
        return seq[pos % 255];
    endfunction

    // Called just after a falling edge; leaves the DUT out of reset, idle.
    task automatic do_reset();
        en = 1'b0; seed_we = 1'b0; req = 1'b0; rnd_ready = 1'b0;
        seed_in = 8'h00; range_in = 8'h00;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_lfsr", int'(lfsr_q), 'h93);
        check_val("rst_valid", int'(rnd_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_out", int'(rnd_out), 0);
        rst_n = 1'b1;
        pos = 0;
    endtask

    task automatic idle_steps(input int k);
        en = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            pos++;
            check_val("step_lfsr", int'(lfsr_q), cur());
            if (lfsr_q == 8'h00) check_val("step_nonzero", int'(lfsr_q), 1);
        end
        en = 1'b0;
    endtask

    task automatic load_seed(input int v);
        seed_we = 1'b1;
        seed_in = 8'(v);
        @(negedge clk);
        seed_we = 1'b0;
        pos = idx_of(v == 0 ? 'h93 : v);
        check_val("seed_lfsr", int'(lfsr_q), cur());
    endtask

    task automatic do_draw(input int rng, input bit en_v, input int hold,
                           output int got, output int lat);
        int start, m, j, exp_out, cycles;
        start = pos + (en_v ? 1 : 0);
        m = mask_ref(rng);
        j = 0;
        while (j < 255 && !(rng == 0 || (seq[(start + j) % 255] & m) < rng)) j++;
        exp_out = seq[(start + j) % 255] & m;

        req = 1'b1; range_in = 8'(rng); en = en_v;
        @(negedge clk);
        req = 1'b0; en = 1'b0; range_in = 8'($urandom);
        cycles = 1;
        check_val("draw_busy", int'(busy), 1);
        while (!rnd_valid && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        got = int'(rnd_out);
        lat = cycles;
        if (!rnd_valid) begin
            check_val("draw_timeout", cycles, j + 2);
            do_reset();
            return;
        end
        pos = start + j + 1;
        check_val("draw_latency", cycles, j + 2);
        check_val("draw_out", int'(rnd_out), exp_out);
        check_val("draw_lfsr", int'(lfsr_q), cur());

        for (int h = 0; h < hold; h++) begin
            rnd_ready = 1'b0;
            req = 1'($urandom);
            en = 1'($urandom);
            range_in = 8'($urandom);
            @(negedge clk);
            check_val("hold_valid", int'(rnd_valid), 1);
            check_val("hold_out", int'(rnd_out), exp_out);
            check_val("hold_lfsr", int'(lfsr_q), cur());
        end
        rnd_ready = 1'b1;
        req = 1'($urandom);
        en = 1'b0;
        @(negedge clk);
        check_val("ack_valid", int'(rnd_valid), 0);
        check_val("ack_busy", int'(busy), 0);
        rnd_ready = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check_val("post_ack_busy", int'(busy), 0);
        check_val("post_ack_lfsr", int'(lfsr_q), cur());
    endtask

    initial begin
        int got, lat, rng;
        seq[0] = 'h93;
        for (int i = 1; i < 255; i++) seq[i] = step_ref(seq[i-1]);
        pos = 0;

        @(negedge clk);
        do_reset();

        // Free-run from reset: 0x93 -> 0x26 -> 0x4D
        en = 1'b1;
        @(negedge clk);
        check_val("run1", int'(lfsr_q), 'h26);
        @(negedge clk);
        check_val("run2", int'(lfsr_q), 'h4D);
        en = 1'b0;

        // Full period returns to the reset seed, never passing zero
        do_reset();
        idle_steps(255);
        check_val("period", int'(lfsr_q), 'h93);

        // Zero seed falls back to SEED
        idle_steps(7);
        load_seed(0);
        check_val("seed_zero", int'(lfsr_q), 'h93);

        // Directed draws from reset
        do_reset();
        do_draw(16, 1'b0, 0, got, lat);
        check_val("r16_out", got, 'h03);
        check_val("r16_lat", lat, 2);

        do_reset();
        do_draw(0, 1'b0, 0, got, lat);
        check_val("r0_out", got, 'h93);

        do_reset();
        do_draw(3, 1'b0, 0, got, lat);
        check_val("r3_out", got, 2);
        check_val("r3_lat", lat, 3);

        do_reset();
        do_draw(1, 1'b0, 0, got, lat);
        check_val("r1_out", got, 0);
        check_val("r1_lat", lat, 2);

        do_reset();
        do_draw(16, 1'b0, 5, got, lat);

        // Seed written during DRAW: next candidate is the new seed
        do_reset();
        req = 1'b1; range_in = 8'd3;
        @(negedge clk);
        req = 1'b0; seed_we = 1'b1; seed_in = 8'h44;
        @(negedge clk);
        seed_we = 1'b0;
        check_val("sd_still_busy", int'(rnd_valid), 0);
        @(negedge clk);
        check_val("sd_valid", int'(rnd_valid), 1);
        check_val("sd_out", int'(rnd_out), 0);
        pos = idx_of('h44) + 1;
        check_val("sd_lfsr", int'(lfsr_q), cur());
        rnd_ready = 1'b1;
        @(negedge clk);
        rnd_ready = 1'b0;
        check_val("sd_ack", int'(rnd_valid), 0);

        // Asynchronous reset in the middle of a draw
        do_reset();
        idle_steps(5);
        req = 1'b1; range_in = 8'd200;
        @(negedge clk);
        req = 1'b0;
        check_val("mid_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", int'(rnd_valid), 0);
        check_val("mid_rst_busy", int'(busy), 0);
        check_val("mid_rst_lfsr", int'(lfsr_q), 'h93);
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        @(negedge clk);
        check_val("mid_after_busy", int'(busy), 0);

        // Randomized mix of free-run, seed loads and draws
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0: idle_steps($urandom_range(1, 20));
                1: load_seed(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255));
                default: begin
                    rng = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                      : $urandom_range(0, 20);
                    do_draw(rng, 1'($urandom), $urandom_range(0, 5), got, lat);
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rng.md
LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 Parameter WIDTH, default 8, meaning LFSR and output width, legal range 4..32.
REQ-002 Parameter SEED, default 8'b10010011 (0x93), meaning WIDTH-bit reset and fallback seed; SHALL be nonzero.
REQ-003 Parameter TAPS, default 8'hB8, meaning WIDTH-bit feedback mask, maximal-length for the default WIDTH.
REQ-004 clk  input  1  the single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 en  input  1  free-run step enable while idle.
REQ-007 seed_we  input  1  load seed_in into LFSR this cycle.
REQ-008 seed_in  input  WIDTH  new seed value.
REQ-009 lfsr_q  output  WIDTH  current LFSR state.
REQ-010 req  input  1  start a bounded draw; sampled only in IDLE.
REQ-011 range_in  input  WIDTH  exclusive upper bound of the draw; 0 means full range.
REQ-012 rnd_valid  output  1  draw result available.
REQ-013 rnd_ready  input  1  consumer accepts the result.
REQ-014 rnd_out  output  WIDTH  draw result, held stable while rnd_valid=1.
REQ-015 busy  output  1  high in DRAW or OUT.

Function
REQ-016 Step: next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)}.
REQ-017 Step priority: seed_we > step; step occurs when (state==IDLE && en) or state==DRAW; otherwise hold.
REQ-018 seed_we with seed_in==0 SHALL load SEED, never zero (lock-up protection); lfsr_q is never 0.
REQ-019 FSM states: IDLE, DRAW, OUT.
REQ-020 IDLE: on req=1, latch range_in into range_r and compute mask_r = smallest all-ones value >= range_r-1 (all ones when range_r is 0 or exceeds 2^(WIDTH-1)); go to DRAW.
REQ-021 DRAW: each cycle test cand = lfsr_q & mask_r; accept if range_r==0 or cand < range_r; on accept register rnd_out=cand, go to OUT; on reject stay. LFSR steps every DRAW cycle.
REQ-022 Minimum latency: req sampled at edge N -> rnd_valid high after edge N+2; the first candidate is lfsr_q at edge N+1.
REQ-023 Range 1 SHALL yield rnd_out=0 on the first DRAW cycle.
REQ-024 Termination: a draw completes within 2^WIDTH-1 DRAW cycles, because the low bits of a maximal LFSR cover every value.
REQ-025 OUT: rnd_valid=1; on rnd_ready=1 go to IDLE (rnd_valid low the next cycle); rnd_out and rnd_valid hold until then.
REQ-026 req outside IDLE SHALL be ignored; range_in changes outside IDLE SHALL have no effect.
REQ-027 seed_we during DRAW loads the seed; the draw continues, and the next candidate tested is the new seed.
REQ-028 Simultaneous rnd_ready and req in OUT: return to IDLE; req is not accepted until it is sampled in IDLE.

Reset
REQ-029 On rst_n=0, asynchronously: lfsr_q=SEED, state=IDLE, rnd_valid=0, rnd_out=0, busy=0, range_r=0, mask_r=0.
REQ-030 Reset mid-draw SHALL abort the draw with no residual rnd_valid.

Structure
REQ-031 Package lfsr_pkg SHALL hold the FSM state enum (IDLE/DRAW/OUT), default TAPS 8'hB8 and default SEED 8'h93.
REQ-032 One sub-module, lfsr_core (step, seed load, zero protection), instantiated once; the FSM and mask logic live in lfsr_rng.

Verification
REQ-033 Reset, then en=1 for 2 cycles -> lfsr_q 0x93, 0x26, 0x4D.
REQ-034 en=1 for 255 cycles from reset -> returns to 0x93, never 0x00; seed_we with seed_in=0 -> lfsr_q=0x93.
REQ-035 From reset, en=0, req with range_in=16 -> rnd_out=0x03, rnd_valid 2 cycles after req; range_in=0 -> rnd_out=0x93.
REQ-036 From reset, req with range_in=3 -> candidate 3 rejected, then 0x26&3=2 accepted -> rnd_out=2 after 2 DRAW cycles.
REQ-037 rnd_ready held low for 5 cycles -> rnd_valid and rnd_out stable, lfsr_q frozen; req pulses during this time are ignored.
REQ-038 rst_n=0 asserted mid-DRAW -> rnd_valid=0, busy=0, lfsr_q=0x93 immediately, without waiting for a clock edge.
